// File: rtl/shift_tx_pkg.sv
// shift_tx_pkg: shared FSM state type and parameter defaults for shift_tx_param.
// The PARITY state exists only when SHIFT_TX_PARITY_EN is defined.
package shift_tx_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int DIV_DEF = 4;
  localparam bit MSB_FIRST_DEF = 1'b0;
`ifdef SHIFT_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif
endpackage

// File: rtl/shift_tx_baud_div.sv
// shift_tx_baud_div: DIV-cycle bit-rate tick; clear restarts the count so the
// first tick lands DIV-1 cycles after the clearing edge.
module shift_tx_baud_div #(
  parameter int DIV = 4
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic clear,
  output logic tick
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  logic [CW-1:0] cnt;
  assign tick = cnt == CW'(DIV - 1);
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) cnt <= '0;
    else cnt <= (clear || tick) ? '0 : cnt + CW'(1);
endmodule

// File: rtl/shift_tx_param.sv
// shift_tx_param: parallel-load serial transmitter with DIV-cycle bit period.
// Define SHIFT_TX_PARITY_EN to append an even-parity bit after the data bits.
module shift_tx_param
  import shift_tx_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int DIV       = DIV_DEF,
  parameter bit MSB_FIRST = MSB_FIRST_DEF
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [WIDTH-1:0] DIN,
  input  logic             PARALLEL_LOAD,
  input  logic             START_TX,
  output logic             SOUT,
  output logic             TX_BUSY,
  output logic             TX_DONE,
  output logic             LOAD_ERR
);
  localparam int BW = $clog2(WIDTH + 1);
  state_t state;
  logic [WIDTH-1:0] hold, sr;
  logic [BW-1:0] bcnt;
  logic tick, last;
  // Divider is held cleared while idle so the start edge restarts bit timing
  shift_tx_baud_div #(.DIV(DIV)) u_div (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .clear(state == IDLE),
    .tick(tick)
  );
  assign last = bcnt == BW'(WIDTH - 1);
  assign TX_BUSY = state != IDLE;
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      state <= IDLE;
      hold <= '0;
      sr <= '0;
      bcnt <= '0;
      SOUT <= 1'b0;
      TX_DONE <= 1'b0;
      LOAD_ERR <= 1'b0;
    end else begin
      TX_DONE <= 1'b0;
      LOAD_ERR <= PARALLEL_LOAD && state != IDLE;
      case (state)
        IDLE:
          if (PARALLEL_LOAD && !START_TX) hold <= DIN;
          else if (START_TX && !PARALLEL_LOAD) begin
            state <= SHIFT;
            sr <= hold;
            bcnt <= '0;
            SOUT <= MSB_FIRST ? hold[WIDTH-1] : hold[0];
          end
        SHIFT:
          if (tick) begin
            if (last) begin
`ifdef SHIFT_TX_PARITY_EN
              state <= PARITY;
              SOUT <= ^hold;
`else
              state <= IDLE;
              SOUT <= 1'b0;
              TX_DONE <= 1'b1;
`endif
            end else begin
              bcnt <= bcnt + BW'(1);
              sr <= MSB_FIRST ? sr << 1 : sr >> 1;
              SOUT <= MSB_FIRST ? sr[WIDTH-2] : sr[1];
            end
          end
`ifdef SHIFT_TX_PARITY_EN
        PARITY:
          if (tick) begin
            state <= IDLE;
            SOUT <= 1'b0;
            TX_DONE <= 1'b1;
          end
`endif
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_shift_tx_param.sv
// tb_shift_tx_param: scoreboard bench for shift_tx_param (LSB/MSB at DIV=2, LSB at DIV=1).
// Expected timing follows SHIFT_TX_PARITY_EN when the bench is built with it.
module tb_shift_tx_param;
`ifdef SHIFT_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int W = 8;
  localparam int D = 2;
  localparam int FL = (W + PB) * D;
  localparam int FLF = W + PB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] din = '0, din_f = '0;
  logic load = 1'b0, start = 1'b0, load_f = 1'b0, start_f = 1'b0;
  logic sout_l, busy_l, done_l, err_l;
  logic sout_m, busy_m, done_m, err_m;
  logic sout_f, busy_f, done_f, err_f;
  logic [7:0] held = '0, held_f = '0;
  logic q_l[$], q_m[$], q_f[$];
  int n_pass = 0, n_total = 0;

  always #5 clk = ~clk;

  shift_tx_param #(.WIDTH(W), .DIV(D), .MSB_FIRST(1'b0)) u_lsb (
    .CLK(clk), .RESET_N(rst_n), .DIN(din), .PARALLEL_LOAD(load), .START_TX(start),
    .SOUT(sout_l), .TX_BUSY(busy_l), .TX_DONE(done_l), .LOAD_ERR(err_l));
  shift_tx_param #(.WIDTH(W), .DIV(D), .MSB_FIRST(1'b1)) u_msb (
    .CLK(clk), .RESET_N(rst_n), .DIN(din), .PARALLEL_LOAD(load), .START_TX(start),
    .SOUT(sout_m), .TX_BUSY(busy_m), .TX_DONE(done_m), .LOAD_ERR(err_m));
  shift_tx_param #(.WIDTH(W), .DIV(1), .MSB_FIRST(1'b0)) u_fast (
    .CLK(clk), .RESET_N(rst_n), .DIN(din_f), .PARALLEL_LOAD(load_f), .START_TX(start_f),
    .SOUT(sout_f), .TX_BUSY(busy_f), .TX_DONE(done_f), .LOAD_ERR(err_f));

  task automatic push_frame(input logic [7:0] w);
    for (int k = 0; k < W; k++)
      for (int r = 0; r < D; r++) begin
        q_l.push_back(w[k]);
        q_m.push_back(w[W-1-k]);
      end
`ifdef SHIFT_TX_PARITY_EN
    for (int r = 0; r < D; r++) begin
      q_l.push_back(^w);
      q_m.push_back(^w);
    end
`endif
  endtask

  task automatic do_load(input logic [7:0] w);
    logic [3:0] got;
    @(negedge clk);
    din = w;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    held = w;
    got = {busy_l, busy_m, err_l, err_m};
    n_total++;
    if (got !== 4'b0000) $display("FAIL load %h: busy/err got=%b exp=0000", w, got);
    else n_pass++;
  endtask

  // Starts a frame of the held word; err_at/rst_at inject a busy load or a reset at that cycle
  task automatic run_frame(input int err_at, input int rst_at);
    logic [7:0] got, exp_v;
    logic el, em;
    @(negedge clk);
    start = 1'b1;
    push_frame(held);
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < FL; c++) begin
      el = q_l.size() > 0 ? q_l.pop_front() : 1'bx;
      em = q_m.size() > 0 ? q_m.pop_front() : 1'bx;
      got = {sout_l, sout_m, busy_l, busy_m, done_l, done_m, err_l, err_m};
      exp_v = {el, em, 1'b1, 1'b1, 1'b0, 1'b0, c == err_at, c == err_at};
      n_total++;
      if (got !== exp_v) $display("FAIL frame %h cycle %0d: sout/busy/done/err got=%b exp=%b", held, c, got, exp_v);
      else n_pass++;
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        got = {sout_l, sout_m, busy_l, busy_m, done_l, done_m, err_l, err_m};
        n_total++;
        if (got !== 8'h00) $display("FAIL async reset mid-frame: got=%b exp=00000000", got);
        else n_pass++;
        q_l.delete();
        q_m.delete();
        held = '0;
        repeat (2) begin
          @(negedge clk);
          got = {sout_l, sout_m, busy_l, busy_m, done_l, done_m, err_l, err_m};
          n_total++;
          if (got !== 8'h00) $display("FAIL held in reset: got=%b exp=00000000", got);
          else n_pass++;
        end
        rst_n = 1'b1;
        return;
      end
      load = (c + 1 == err_at);
      if (load) din = 8'hFF;
      @(negedge clk);
    end
    load = 1'b0;
    got = {sout_l, sout_m, busy_l, busy_m, done_l, done_m, err_l, err_m};
    n_total++;
    if (got !== 8'b0000_1100) $display("FAIL frame %h done cycle: got=%b exp=00001100", held, got);
    else n_pass++;
    @(negedge clk);
    got = {sout_l, sout_m, busy_l, busy_m, done_l, done_m, err_l, err_m};
    n_total++;
    if (got !== 8'h00) $display("FAIL frame %h after done: got=%b exp=00000000", held, got);
    else n_pass++;
  endtask

  task automatic test_reset;
    logic [11:0] got;
    repeat (2) @(negedge clk);
    got = {sout_l, busy_l, done_l, err_l, sout_m, busy_m, done_m, err_m, sout_f, busy_f, done_f, err_f};
    n_total++;
    if (got !== 12'h000) $display("FAIL reset outputs: got=%b exp=000000000000", got);
    else n_pass++;
    rst_n = 1'b1;
    run_frame(-1, -1);
  endtask

  task automatic test_order;
    do_load(8'hA5);
    run_frame(-1, -1);
    do_load(8'h0F);
    run_frame(-1, -1);
  endtask

  task automatic test_load_err;
    do_load(8'hA5);
    run_frame(5, -1);
    run_frame(-1, -1);
  endtask

  task automatic test_both_high;
    logic [7:0] got;
    @(negedge clk);
    din = 8'hC3;
    load = 1'b1;
    start = 1'b1;
    @(negedge clk);
    load = 1'b0;
    start = 1'b0;
    got = {sout_l, sout_m, busy_l, busy_m, done_l, done_m, err_l, err_m};
    n_total++;
    if (got !== 8'h00) $display("FAIL load+start ignored: got=%b exp=00000000", got);
    else n_pass++;
    run_frame(-1, -1);
  endtask

  task automatic test_reset_mid;
    run_frame(-1, 7);
    do_load(8'h3C);
    run_frame(-1, -1);
  endtask

  task automatic test_back_to_back;
    logic [3:0] got, exp_v;
    logic e;
    @(negedge clk);
    din_f = 8'h07;
    load_f = 1'b1;
    @(negedge clk);
    load_f = 1'b0;
    held_f = 8'h07;
    start_f = 1'b1;
    @(negedge clk);
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < W; k++) q_f.push_back(held_f[k]);
      if (PB == 1) q_f.push_back(^held_f);
      for (int c = 0; c < FLF; c++) begin
        e = q_f.size() > 0 ? q_f.pop_front() : 1'bx;
        got = {sout_f, busy_f, done_f, err_f};
        exp_v = {e, 1'b1, 1'b0, 1'b0};
        n_total++;
        if (got !== exp_v) $display("FAIL back-to-back frame %0d cycle %0d: got=%b exp=%b", f, c, got, exp_v);
        else n_pass++;
        @(negedge clk);
      end
      got = {sout_f, busy_f, done_f, err_f};
      n_total++;
      if (got !== 4'b0010) $display("FAIL back-to-back frame %0d done gap: got=%b exp=0010", f, got);
      else n_pass++;
      if (f == 2) start_f = 1'b0;
      @(negedge clk);
    end
    got = {sout_f, busy_f, done_f, err_f};
    n_total++;
    if (got !== 4'b0000) $display("FAIL back-to-back stop: got=%b exp=0000", got);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_order;
    test_load_err;
    test_both_high;
    test_reset_mid;
    test_back_to_back;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/shift_tx_param.md
SHIFT_TX_PARAM -- requirements
Module: shift_tx_param

Interface
REQ-001 Parameter WIDTH, default 32: data word width in bits, legal range 2..64.
REQ-002 Parameter DIV, default 4: CLK cycles per serial bit, legal range 1..65535.
REQ-003 Parameter MSB_FIRST, default 0: 0 = shift LSB first, 1 = MSB first.
REQ-004 CLK  input  1: single clock; all logic on rising edge.
REQ-005 RESET_N  input  1: asynchronous, active-low reset.
REQ-006 DIN  input  WIDTH: parallel data word.
REQ-007 PARALLEL_LOAD  input  1: capture DIN into holding register.
REQ-008 START_TX  input  1: begin transmission of held word.
REQ-009 SOUT  output  1: serial data, registered.
REQ-010 TX_BUSY  output  1: transmission in progress.
REQ-011 TX_DONE  output  1: one-cycle completion pulse.
REQ-012 LOAD_ERR  output  1: one-cycle pulse, load rejected.

Function
REQ-013 FSM states SHALL be IDLE, SHIFT and (with PARITY_EN) PARITY; TX_BUSY SHALL be 1 exactly when state != IDLE.
REQ-014 In IDLE, PARALLEL_LOAD=1 with START_TX=0 SHALL capture DIN at that edge.
REQ-015 In IDLE, START_TX=1 with PARALLEL_LOAD=0 at edge E0 SHALL enter SHIFT, set TX_BUSY=1 and drive the first bit on SOUT from E0.
REQ-016 Bit k (k=0..WIDTH-1) SHALL be held on SOUT from edge E0+k*DIV for exactly DIV cycles; bit order per MSB_FIRST.
REQ-017 Bit timing SHALL come from a DIV-cycle tick counter reset at E0; bit counter width SHALL be $clog2(WIDTH+1).
REQ-018 Without PARITY_EN, at edge E0+WIDTH*DIV the block SHALL return to IDLE: TX_BUSY=0, SOUT=0, TX_DONE=1 for that one cycle.
REQ-019 PARALLEL_LOAD and START_TX both high in IDLE SHALL be ignored, with no state change and no LOAD_ERR.
REQ-020 START_TX while busy SHALL be ignored.
REQ-021 PARALLEL_LOAD while busy SHALL leave the holding register and transmission unchanged and pulse LOAD_ERR for one cycle.
REQ-022 START_TX in the TX_DONE cycle SHALL be accepted, since the state is already IDLE, and SHALL retransmit the held word.
REQ-023 The held word SHALL persist after transmission until the next accepted load.
REQ-024 SOUT SHALL be 0 whenever in IDLE.

Reset
REQ-025 RESET_N low SHALL immediately force state=IDLE, holding register=0, counters=0, SOUT=0, TX_BUSY=0, TX_DONE=0 and LOAD_ERR=0.
REQ-026 Reset mid-transmission SHALL abort with no TX_DONE pulse; after release the block SHALL accept a new load/start normally.

Configuration
REQ-027 Macro SHIFT_TX_PARITY_EN, when defined, SHALL add the PARITY state.
REQ-028 With the macro defined, the even-parity bit (XOR of the held word) SHALL be driven for DIV cycles from E0+WIDTH*DIV, and completion SHALL move to E0+(WIDTH+1)*DIV.
REQ-029 Without the macro, no parity logic SHALL be synthesised and timing SHALL follow REQ-018.

Structure
REQ-030 Package shift_tx_pkg SHALL hold the state enum typedef and the default values of WIDTH, DIV and MSB_FIRST.
REQ-031 Bit-rate tick generation SHALL be a sub-module, shift_tx_baud_div (parameter DIV; ports CLK, RESET_N, clear, tick).

Verification
REQ-032 WIDTH=8, DIV=2, LSB first: load 8'hA5, then START_TX -> SOUT 1,0,1,0,0,1,0,1, each bit 2 cycles; TX_DONE at E0+16; TX_BUSY high 16 cycles.
REQ-033 Same stimulus with MSB_FIRST=1 -> SOUT 1,0,1,0,0,1,0,1 (palindrome check); repeat with 8'h0F -> 0,0,0,0,1,1,1,1.
REQ-034 PARALLEL_LOAD of 8'hFF at E0+5 during transmission of 8'hA5 -> LOAD_ERR pulse; remaining bits unchanged; next start retransmits 8'hA5.
REQ-035 RESET_N low at E0+7 -> SOUT=0 and TX_BUSY=0 immediately, no TX_DONE; after release, load 8'h3C and start -> correct frame.
REQ-036 SHIFT_TX_PARITY_EN defined, WIDTH=8, DIV=1, word 8'h07 -> parity bit 1 at E0+8; TX_DONE at E0+9.
REQ-037 START_TX held high continuously with DIV=1 -> back-to-back frames, TX_DONE every WIDTH+1 cycles (the idle gap is the TX_DONE cycle, where SOUT=0).
